// File: rtl/mem_access.sv
// MIPS MEM stage: issues loads/stores on a req/ack data bus with big-endian lane and sign handling.
// It also forwards ALU results and HI/LO updates to mem_wb and stalls upstream while a bus access is open.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mem_op_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [4:0]  w_reg_addr_in,
    input  logic [31:0] w_reg_data_in,
    input  logic        w_reg_en_in,
    input  logic [31:0] hi_regs_in,
    input  logic [31:0] lo_regs_in,
    input  logic        hilo_wen_in,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [4:0]  w_reg_addr_out,
    output logic [31:0] w_reg_data_out,
    output logic        w_reg_en_out,
    output logic [31:0] hi_regs_out,
    output logic [31:0] lo_regs_out,
    output logic        hilo_wen_out,
    output logic        stall_req,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;
    logic        w_req;
    logic        w_done;
    logic        w_stall;
    logic        w_addr_err;
    logic        w_bus_err;

    // State register and ack-wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Op decode: access class, alignment, byte enables, replicated store data.
    always_comb begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = 32'h0000_0000;
        case (mem_op_in)
            OP_LB, OP_LBU: begin
                w_be = 4'b1000 >> mem_addr_in[1:0];
            end
            OP_LH, OP_LHU: begin
                w_misalign = mem_addr_in[0];
                w_be       = mem_addr_in[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: begin
                w_misalign = (mem_addr_in[1:0] != 2'b00);
                w_be       = 4'b1111;
            end
            OP_SB: begin
                w_is_store = 1'b1;
                w_be       = 4'b1000 >> mem_addr_in[1:0];
                w_wdata    = {4{mem_wdata_in[7:0]}};
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_misalign = mem_addr_in[0];
                w_be       = mem_addr_in[1] ? 4'b0011 : 4'b1100;
                w_wdata    = {2{mem_wdata_in[15:0]}};
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_misalign = (mem_addr_in[1:0] != 2'b00);
                w_be       = 4'b1111;
                w_wdata    = mem_wdata_in;
            end
            default: begin
                w_is_mem = 1'b0;
            end
        endcase
    end

    // Next-state: an ack in the request cycle finishes without ever entering WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem && !w_misalign && !dbus_ack) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dbus_ack || (r_cnt == TIMEOUT_C)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Handshake outputs; operands stay valid in WAIT because upstream is stalled.
    always_comb begin
        w_req      = 1'b0;
        w_done     = 1'b0;
        w_stall    = 1'b0;
        w_addr_err = 1'b0;
        w_bus_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req      = w_is_mem && !w_misalign;
                w_done     = w_req && dbus_ack;
                w_stall    = w_req && !dbus_ack;
                w_addr_err = w_is_mem && w_misalign;
            end
            ST_WAIT: begin
                w_done    = dbus_ack;
                w_bus_err = !dbus_ack && (r_cnt == TIMEOUT_C);
                w_req     = !w_bus_err;
                w_stall   = !dbus_ack && !w_bus_err;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    // Load lane extraction (byte offset 0 is the most significant lane).
    always_comb begin
        case (mem_addr_in[1:0])
            2'd0:    w_lane_byte = dbus_rdata[31:24];
            2'd1:    w_lane_byte = dbus_rdata[23:16];
            2'd2:    w_lane_byte = dbus_rdata[15:8];
            default: w_lane_byte = dbus_rdata[7:0];
        endcase
        w_lane_half = mem_addr_in[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
        case (mem_op_in)
            OP_LB:   w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            OP_LBU:  w_load_data = {24'h00_0000, w_lane_byte};
            OP_LH:   w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            OP_LHU:  w_load_data = {16'h0000, w_lane_half};
            OP_LW:   w_load_data = dbus_rdata;
            default: w_load_data = w_reg_data_in;
        endcase
    end

    // Port drive; everything is held at zero while rst_n is low.
    always_comb begin
        if (rst_n) begin
            dbus_req       = w_req;
            dbus_we        = w_req && w_is_store;
            dbus_be        = w_req ? w_be : 4'b0000;
            dbus_addr      = w_req ? {mem_addr_in[31:2], 2'b00} : 32'h0000_0000;
            dbus_wdata     = w_req ? w_wdata : 32'h0000_0000;
            w_reg_addr_out = w_reg_addr_in;
            w_reg_data_out = w_load_data;
            w_reg_en_out   = w_is_mem ? (w_done && w_reg_en_in) : w_reg_en_in;
            hi_regs_out    = hi_regs_in;
            lo_regs_out    = lo_regs_in;
            hilo_wen_out   = hilo_wen_in;
            stall_req      = w_stall;
            addr_err       = w_addr_err;
            bus_err        = w_bus_err;
        end else begin
            dbus_req       = 1'b0;
            dbus_we        = 1'b0;
            dbus_be        = 4'b0000;
            dbus_addr      = 32'h0000_0000;
            dbus_wdata     = 32'h0000_0000;
            w_reg_addr_out = 5'd0;
            w_reg_data_out = 32'h0000_0000;
            w_reg_en_out   = 1'b0;
            hi_regs_out    = 32'h0000_0000;
            lo_regs_out    = 32'h0000_0000;
            hilo_wen_out   = 1'b0;
            stall_req      = 1'b0;
            addr_err       = 1'b0;
            bus_err        = 1'b0;
        end
    end

endmodule
